// File: rtl/bus_arb_pkg.sv
// Shared definitions for the serial-address bus arbiter family.
// Holds the FSM state encoding, the grant-mode constants and an index-width helper.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CONNECT = 3'd2,
    BUSY    = 3'd3
  } state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Index width that never collapses to zero bits for single-entry vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational grant picker: fixed priority (lowest index) or round-robin
// starting from the entry after 'last', wrapping.
module rr_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int   N    = 2,
  parameter logic MODE = ARB_RR,
  localparam int  MW   = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] last,
  output logic          grant_valid,
  output logic [MW-1:0] grant_idx
);

  int w_scan;

  // Scan from farthest to nearest candidate so the nearest requester is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_scan      = 0;
    if (MODE == ARB_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant_valid = 1'b1;
          grant_idx   = MW'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        w_scan = (int'(last) + k) % N;
        if (req[w_scan]) begin
          grant_valid = 1'b1;
          grant_idx   = MW'(w_scan);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Serial-address bus arbiter: grants one master, shifts in its slave address,
// connects it to that slave and routes its serial signals until release or timeout.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int  NUM_MASTERS = 2,
  parameter int  NUM_SLAVES  = 3,
  parameter int  ADDR_W      = 2,
  parameter int  RR_MODE     = 1,
  parameter int  TIMEOUT     = 16,
  localparam int MW          = idx_width(NUM_MASTERS),
  localparam int SW          = idx_width(NUM_SLAVES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_available,
  output logic [NUM_MASTERS-1:0] m_error,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  output logic [2:0]             state,
  output logic [MW-1:0]          owner,
  output logic [SW-1:0]          slave_sel
);

  localparam int BCW = idx_width(ADDR_W + 1);
  localparam int ICW = idx_width(TIMEOUT);

  state_t                 r_state;
  logic [MW-1:0]          r_owner;
  logic [MW-1:0]          r_last_owner;
  logic [SW-1:0]          r_slave_sel;
  logic [ADDR_W-1:0]      r_addr_buf;
  logic [BCW-1:0]         r_bit_cnt;
  logic [NUM_SLAVES-1:0]  r_connect;
  logic [ICW-1:0]         r_idle_cnt;
  logic [NUM_MASTERS-1:0] r_error;

  logic                   w_grant_valid;
  logic [MW-1:0]          w_grant_idx;
  logic                   w_addr_ok;
  logic [NUM_SLAVES-1:0]  w_onehot;

  rr_priority_picker #(
    .N    (NUM_MASTERS),
    .MODE ((RR_MODE != 0) ? ARB_RR : ARB_FIXED)
  ) u_picker (
    .req         (m_request & m_address_valid),
    .last        (r_last_owner),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_addr_ok = (int'(r_addr_buf) < NUM_SLAVES);
    w_onehot  = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      w_onehot[j] = (int'(r_addr_buf) == j);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= MW'(NUM_MASTERS - 1);
      r_slave_sel  <= '0;
      r_addr_buf   <= '0;
      r_bit_cnt    <= '0;
      r_connect    <= '0;
      r_idle_cnt   <= '0;
      r_error      <= '0;
    end else begin
      r_error <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant_idx;
            r_last_owner <= w_grant_idx;
            r_bit_cnt    <= '0;
            r_state      <= ADDR;
          end
        end
        ADDR: begin
          // Bits arrive on the ADDR_W edges after entry; the following edge moves on.
          if (!m_request[r_owner]) begin
            r_connect <= '0;
            r_state   <= IDLE;
          end else if (r_bit_cnt == BCW'(ADDR_W)) begin
            r_state <= CONNECT;
          end else begin
            r_addr_buf <= ADDR_W'({r_addr_buf, m_address[r_owner]});
            r_bit_cnt  <= r_bit_cnt + 1'b1;
          end
        end
        CONNECT: begin
          if (w_addr_ok) begin
            r_slave_sel <= SW'(r_addr_buf);
            r_connect   <= w_onehot;
            r_idle_cnt  <= '0;
            r_state     <= BUSY;
          end else begin
            r_error[r_owner] <= 1'b1;
            r_connect        <= '0;
            r_state          <= IDLE;
          end
        end
        BUSY: begin
          if (!m_request[r_owner]) begin
            r_connect <= '0;
            r_state   <= IDLE;
          end else if (m_address_valid[r_owner]) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_state    <= ADDR;
          end else if (m_valid[r_owner]) begin
            r_idle_cnt <= '0;
          end else if (TIMEOUT != 0) begin
            if (r_idle_cnt == ICW'(TIMEOUT - 1)) begin
              r_error[r_owner] <= 1'b1;
              r_connect        <= '0;
              r_state          <= IDLE;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_connect <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Routing is purely a function of the registered connection and owner.
  always_comb begin
    s_address   = '0;
    s_data      = '0;
    s_valid     = '0;
    m_ready     = '0;
    m_available = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (r_connect[j]) begin
        s_address[j] = m_address[r_owner];
        s_data[j]    = m_data[r_owner];
        s_valid[j]   = m_valid[r_owner] & (r_state == BUSY);
      end
    end
    if (r_state == BUSY) begin
      m_ready[r_owner] = s_ready[r_slave_sel];
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_available[i] = (r_state == IDLE) | (int'(r_owner) == i);
    end
  end

  assign m_error   = r_error;
  assign state     = r_state;
  assign owner     = r_owner;
  assign slave_sel = r_slave_sel;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus randomized transactions,
// checked against a transaction-level model of grant order, timing and routing.
module tb_bus_arbiter_rr;
  import bus_arb_pkg::*;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NM-1:0] m_request, m_address_valid, m_address, m_data, m_valid;
  logic [NM-1:0] m_ready, m_available, m_error;
  logic [NS-1:0] s_address, s_data, s_valid, s_ready;
  logic [2:0]    state;
  logic [0:0]    owner;
  logic [1:0]    slave_sel;

  logic [NM-1:0] f_request, f_address_valid, f_address, f_data, f_valid;
  logic [NM-1:0] f_ready, f_available, f_error;
  logic [NS-1:0] f_s_address, f_s_data, f_s_valid, f_s_ready;
  logic [2:0]    f_state;
  logic [0:0]    f_owner;
  logic [1:0]    f_slave_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_last;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .RR_MODE(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .m_request(m_request), .m_address_valid(m_address_valid),
    .m_address(m_address), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_available(m_available), .m_error(m_error), .s_address(s_address), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .state(state), .owner(owner), .slave_sel(slave_sel)
  );

  bus_arbiter_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .RR_MODE(0), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .reset_n(reset_n), .m_request(f_request), .m_address_valid(f_address_valid),
    .m_address(f_address), .m_data(f_data), .m_valid(f_valid), .m_ready(f_ready),
    .m_available(f_available), .m_error(f_error), .s_address(f_s_address), .s_data(f_s_data),
    .s_valid(f_s_valid), .s_ready(f_s_ready), .state(f_state), .owner(f_owner), .slave_sel(f_slave_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester after the previous winner, wrapping.
  function automatic int model_pick(input logic [NM-1:0] mask);
    for (int k = 1; k <= NM; k++) begin
      if (mask[(mdl_last + k) % NM]) return (mdl_last + k) % NM;
    end
    return 0;
  endfunction

  task automatic noise();
    m_address       = NM'($urandom);
    m_data          = NM'($urandom);
    m_valid         = NM'($urandom);
    s_ready         = NS'($urandom);
    m_address_valid = '0;
  endtask

  task automatic check_route(input string tag, input int w, input int sl, input bit busy);
    logic [NS-1:0] ea, ed, ev;
    logic [NM-1:0] er;
    ea = '0; ed = '0; ev = '0; er = '0;
    if (sl >= 0) begin
      ea[sl] = m_address[w];
      ed[sl] = m_data[w];
      if (busy) ev[sl] = m_valid[w];
    end
    if (busy) er[w] = s_ready[sl];
    check({tag, ".s_address"}, 32'(s_address), 32'(ea));
    check({tag, ".s_data"}, 32'(s_data), 32'(ed));
    check({tag, ".s_valid"}, 32'(s_valid), 32'(ev));
    check({tag, ".m_ready"}, 32'(m_ready), 32'(er));
    check({tag, ".m_available"}, 32'(m_available), 32'(NM'(1) << w));
  endtask

  task automatic grant(input logic [NM-1:0] mask, output int w);
    w = model_pick(mask);
    noise();
    m_request       = mask;
    m_address_valid = mask;
    #1;
    check("idle.state", 32'(state), 32'(IDLE));
    check("idle.m_available", 32'(m_available), 32'({NM{1'b1}}));
    tick();
    mdl_last = w;
    check("grant.state", 32'(state), 32'(ADDR));
    check("grant.owner", 32'(owner), 32'(w));
    check("grant.m_available", 32'(m_available), 32'(NM'(1) << w));
  endtask

  // Starts in the first ADDR cycle; returns with the result of the CONNECT edge checked.
  task automatic addr_phase(input int w, input logic [AW-1:0] addr, input int old_sl, output bit ok);
    for (int b = AW - 1; b >= 0; b--) begin
      noise();
      m_request    = NM'(1) << w;
      m_address[w] = addr[b];
      #1;
      check("addr.state", 32'(state), 32'(ADDR));
      check_route("addr", w, old_sl, 1'b0);
      tick();
    end
    noise();
    #1;
    check_route("addr.last", w, old_sl, 1'b0);
    tick();
    noise();
    #1;
    check("connect.state", 32'(state), 32'(CONNECT));
    check_route("connect", w, old_sl, 1'b0);
    tick();
    ok = (int'(addr) < NS);
    if (ok) begin
      check("busy.state", 32'(state), 32'(BUSY));
      check("busy.slave_sel", 32'(slave_sel), 32'(addr));
      check("busy.m_error", 32'(m_error), 32'(0));
    end else begin
      check("badaddr.state", 32'(state), 32'(IDLE));
      check("badaddr.m_error", 32'(m_error), 32'(NM'(1) << w));
      check("badaddr.s_valid", 32'(s_valid), 32'(0));
      check("badaddr.s_address", 32'(s_address), 32'(0));
      m_request = '0;
      tick();
      check("badaddr.pulse_end", 32'(m_error), 32'(0));
    end
  endtask

  // vmode: 0 = m_valid low, 1 = random, 2 = high every third cycle, 3 = always high.
  task automatic busy_phase(input int w, input int sl, input int n, input int vmode, output bit timed_out);
    int streak;
    streak    = 0;
    timed_out = 1'b0;
    for (int c = 0; c < n && !timed_out; c++) begin
      noise();
      m_request = NM'(1) << w;
      case (vmode)
        0:       m_valid[w] = 1'b0;
        2:       m_valid[w] = (c % 3 == 2);
        3:       m_valid[w] = 1'b1;
        default: ;
      endcase
      #1;
      check("busy.state", 32'(state), 32'(BUSY));
      check("busy.slave_sel", 32'(slave_sel), 32'(sl));
      check("busy.m_error", 32'(m_error), 32'(0));
      check_route("busy", w, sl, 1'b1);
      streak = m_valid[w] ? 0 : streak + 1;
      tick();
      if (streak == TO) begin
        timed_out = 1'b1;
        check("timeout.state", 32'(state), 32'(IDLE));
        check("timeout.m_error", 32'(m_error), 32'(NM'(1) << w));
        check("timeout.s_valid", 32'(s_valid), 32'(0));
        m_request = '0;
        tick();
        check("timeout.pulse_end", 32'(m_error), 32'(0));
      end
    end
  endtask

  task automatic release_bus();
    noise();
    m_request = '0;
    tick();
    check("release.state", 32'(state), 32'(IDLE));
    check("release.m_available", 32'(m_available), 32'({NM{1'b1}}));
    check("release.s_address", 32'(s_address), 32'(0));
    check("release.s_valid", 32'(s_valid), 32'(0));
    check("release.m_ready", 32'(m_ready), 32'(0));
  endtask

  task automatic readdress(input int w);
    noise();
    m_request          = NM'(1) << w;
    m_address_valid[w] = 1'b1;
    tick();
    check("readdr.state", 32'(state), 32'(ADDR));
    check("readdr.owner", 32'(owner), 32'(w));
  endtask

  task automatic fp_round();
    f_request = '1; f_address_valid = '1; f_address = '0; f_valid = '0; f_data = '0; f_s_ready = '0;
    tick();
    check("fp.owner", 32'(f_owner), 32'(0));
    check("fp.state", 32'(f_state), 32'(ADDR));
    check("fp.m_available", 32'(f_available), 32'(1));
    f_request = 2'b01;
    f_address_valid = '0;
    repeat (AW + 2) tick();
    check("fp.busy", 32'(f_state), 32'(BUSY));
    f_valid = 2'b01;
    repeat (5) tick();
    f_request = '0;
    f_valid = '0;
    tick();
    check("fp.release", 32'(f_state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bit ok, tmo;
    logic [NM-1:0] mask;
    logic [AW-1:0] addr, addr2;

    m_request = '0; m_address_valid = '0; m_address = '0; m_data = '0; m_valid = '0; s_ready = '0;
    f_request = '0; f_address_valid = '0; f_address = '0; f_data = '0; f_valid = '0; f_s_ready = '0;
    tick();
    tick();
    check("reset.state", 32'(state), 32'(IDLE));
    check("reset.owner", 32'(owner), 32'(0));
    check("reset.slave_sel", 32'(slave_sel), 32'(0));
    check("reset.m_available", 32'(m_available), 32'({NM{1'b1}}));
    check("reset.m_error", 32'(m_error), 32'(0));
    check("reset.s_valid", 32'(s_valid), 32'(0));
    reset_n  = 1'b1;
    mdl_last = NM - 1;

    // Round robin: simultaneous requests alternate 0,1,0.
    for (int r = 0; r < 3; r++) begin
      grant(2'b11, w);
      check("rr.sequence", 32'(owner), 32'(r % 2));
      addr = AW'($urandom_range(0, NS - 1));
      addr_phase(w, addr, -1, ok);
      busy_phase(w, int'(addr), 5, 3, tmo);
      release_bus();
    end

    // Fixed priority instance always grants master 0.
    repeat (3) fp_round();

    // Single master to slave 1.
    grant(2'b01, w);
    addr_phase(w, 2'b01, -1, ok);
    busy_phase(w, 1, 6, 1, tmo);
    if (!tmo) release_bus();

    // Out-of-range address from master 1.
    grant(2'b10, w);
    addr_phase(w, 2'b11, -1, ok);

    // Silent owner gets reclaimed; activity every third cycle keeps the bus.
    grant(2'b01, w);
    addr_phase(w, 2'b00, -1, ok);
    busy_phase(w, 0, 10, 0, tmo);
    check("timeout.fired", 32'(tmo), 32'(1));
    grant(2'b01, w);
    addr_phase(w, 2'b10, -1, ok);
    busy_phase(w, 2, 12, 2, tmo);
    check("timeout.held", 32'(state), 32'(BUSY));
    release_bus();

    // Re-address from slave 0 to slave 2.
    grant(2'b01, w);
    addr_phase(w, 2'b00, -1, ok);
    busy_phase(w, 0, 3, 3, tmo);
    readdress(w);
    addr_phase(w, 2'b10, 0, ok);
    busy_phase(w, 2, 3, 3, tmo);
    release_bus();

    // Request dropped mid-address aborts without error.
    grant(2'b10, w);
    noise();
    m_request = NM'(1) << w;
    tick();
    m_request = '0;
    tick();
    check("abort.state", 32'(state), 32'(IDLE));
    check("abort.m_error", 32'(m_error), 32'(0));
    check("abort.m_available", 32'(m_available), 32'({NM{1'b1}}));

    // Asynchronous reset between edges in ADDR.
    grant(2'b11, w);
    noise();
    m_request = NM'(1) << w;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("areset.state", 32'(state), 32'(IDLE));
    check("areset.owner", 32'(owner), 32'(0));
    check("areset.m_available", 32'(m_available), 32'({NM{1'b1}}));
    check("areset.s_address", 32'(s_address), 32'(0));
    check("areset.m_error", 32'(m_error), 32'(0));
    m_request = '0;
    tick();
    reset_n  = 1'b1;
    mdl_last = NM - 1;
    grant(2'b11, w);
    addr_phase(w, 2'b01, -1, ok);
    busy_phase(w, 1, 2, 3, tmo);
    release_bus();

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      mask = NM'($urandom_range(1, 3));
      addr = AW'($urandom_range(0, 3));
      grant(mask, w);
      addr_phase(w, addr, -1, ok);
      if (ok) begin
        busy_phase(w, int'(addr), $urandom_range(2, 8), 1, tmo);
        if (!tmo && $urandom_range(0, 3) == 0) begin
          addr2 = AW'($urandom_range(0, 3));
          readdress(w);
          addr_phase(w, addr2, int'(addr), ok);
          if (ok) begin
            busy_phase(w, int'(addr2), $urandom_range(2, 6), 1, tmo);
          end
        end
        if (ok && !tmo) release_bus();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised serial-address bus arbiter connecting NUM_MASTERS 1-bit serial masters to NUM_SLAVES 1-bit serial slaves. It is the next-generation interconnect core of the bus design. Compared with the 2×3 arbiter it adds:
- configurable fixed-priority or round-robin grant;
- variable-length serial slave address;
- an error path for out-of-range addresses;
- an inactivity timeout that reclaims a stalled bus.

It sits between the master ports and the slave ports of the top-level bus.

## Interface
Parameters:
- NUM_MASTERS, 2: number of master ports (2..8).
- NUM_SLAVES, 3: number of slave ports (1..2^ADDR_W).
- ADDR_W, 2: serial slave-address length in bits, sent MSB first.
- RR_MODE, 1: 1 = round-robin grant, 0 = fixed priority (lowest index wins).
- TIMEOUT, 16: BUSY cycles with no m_valid and no m_address_valid before forced release. 0 disables the timeout.

Ports (MW = $clog2(NUM_MASTERS), SW = $clog2(NUM_SLAVES)):
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m_request  in  NUM_MASTERS  bus request per master.
- m_address_valid  in  NUM_MASTERS  address phase start; the first address bit is on m_address in the next cycle.
- m_address, m_data, m_valid  in  NUM_MASTERS  serial address, serial data and data-valid per master.
- m_ready  out  NUM_MASTERS  ready routed back from the connected slave.
- m_available  out  NUM_MASTERS  high when the bus is free or this master owns it.
- m_error  out  NUM_MASTERS  one-cycle pulse to the owner on bad address or timeout.
- s_address, s_data, s_valid  out  NUM_SLAVES  routed master signals.
- s_ready  in  NUM_SLAVES  slave ready.
- state  out  3  FSM state, for debug.
- owner  out  MW  index of the granted master; valid when state != IDLE.
- slave_sel  out  SW  index of the connected slave; valid in BUSY.

## Operation
- States: IDLE=0, ADDR=1, CONNECT=2, BUSY=3.
- IDLE:
  - Eligible masters have m_request & m_address_valid.
  - Winner: RR_MODE=0 takes the lowest index. RR_MODE=1 takes the first eligible index after last_owner, wrapping.
  - On a win: latch owner, set last_owner <= winner, clear bit_cnt, go to ADDR.
  - With no eligible master, stay in IDLE.
- ADDR:
  - Each cycle, addr_buf <= {addr_buf[ADDR_W-2:0], m_address[owner]} and bit_cnt increments.
  - After ADDR_W bits, go to CONNECT.
  - If m_request[owner] drops, abort to IDLE with no error.
- CONNECT (one cycle):
  - If addr_buf < NUM_SLAVES: slave_sel <= addr_buf, register the one-hot connect vector, go to BUSY.
  - Otherwise: pulse m_error[owner], clear the connect vector, go to IDLE.
- BUSY:
  - Priority order: ~m_request[owner] goes to IDLE; else m_address_valid[owner] goes to ADDR (re-address, owner kept, connect vector kept until the next CONNECT); else an idle counter reaching TIMEOUT pulses m_error[owner] and goes to IDLE.
  - The idle counter clears on any cycle with m_valid[owner] or m_address_valid[owner], and on BUSY entry.
- Leaving to IDLE clears the connect vector in the same edge.
- Routing (combinational from registered connect/owner):
  - s_address[j] and s_data[j] carry the owner's signals when connect[j] is set, else 0.
  - s_valid[j] carries the owner's m_valid only when connect[j] is set and state == BUSY; it is forced to 0 in ADDR and CONNECT.
  - m_ready[owner] = s_ready[slave_sel] in BUSY; all other bits are 0.
  - m_available[i] = (state == IDLE) | (owner == i).
- Simultaneous requests: exactly one grant; losers keep m_available low until the bus returns to IDLE.
- Reset (asynchronous, any state): state=IDLE, owner=0, last_owner=NUM_MASTERS-1 (so master 0 wins first in RR mode), slave_sel=0, addr_buf=0, bit_cnt=0, connect=0, idle counter=0.
  - All outputs reset to 0, except m_available, which is all-ones.

## Timing
- Request to first address bit: the edge that samples m_request & m_address_valid in IDLE enters ADDR. Address bits are sampled on the following ADDR_W edges.
- Address to connection: CONNECT occupies 1 cycle, then BUSY. With request at edge 0, BUSY is entered at edge ADDR_W+2 and s_valid is live from that cycle.
- Errors: m_error is registered and high for exactly one cycle, the cycle after the CONNECT or timeout edge.
- Release: m_request low in BUSY gives IDLE at the next edge. A new grant takes one further edge.
- Timeout: with no activity, release happens at the TIMEOUT-th BUSY cycle after the last activity.

## Structure
- Shared package bus_arb_pkg holds: the state encoding (state_t, localparams IDLE/ADDR/CONNECT/BUSY) and the mode constants ARB_FIXED=0 and ARB_RR=1.
- Sub-module rr_priority_picker: parameter N plus mode; inputs req[N] and last[MW]; outputs grant_valid and grant_idx. It is purely combinational and reused by future bus bridges.
- Top-level width defaults are instantiated as 2 masters × 3 slaves, ADDR_W=2.

## Test plan
- Single master: m0 requests with address 2'b01, then sends data → at edge 4 state=BUSY, slave_sel=1, s_valid[1] follows m_valid[0], m_ready[0]=s_ready[1].
- Round robin: m0 and m1 request together three times, each releasing after 5 cycles → grants go 0,1,0. With RR_MODE=0, all three grants go to m0.
- Bad address: NUM_SLAVES=3, m1 sends 2'b11 → m_error[1] pulses one cycle, state returns to IDLE, all s_valid stay 0.
- Timeout: TIMEOUT=4, m0 is in BUSY with m_valid low → after 4 idle cycles m_error[0] pulses and state=IDLE. Toggling m_valid every 3 cycles prevents the release.
- Re-address: in BUSY on slave 0, m0 asserts m_address_valid and sends 2'b10 → s_valid stays 0 during ADDR/CONNECT, then slave 2 is connected and owner stays 0.
- Async reset mid-ADDR: drop reset_n between edges → all outputs go to reset values immediately, and the next request is granted normally.
